// File: rtl/freq_divider_prog_if.sv
// Interface for freq_divider_prog: run enables, valid/ready divisor config
// port and the per-channel divided-clock / tick / pending outputs.
// Optional macro FDIV_SYNC_EN adds the global sync line.
interface freq_divider_prog_if #(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 16,
   parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic [NUM_CH-1:0] en;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] pending;
`ifdef FDIV_SYNC_EN
   logic              sync;
`endif

   modport master (
      output en, cfg_valid, cfg_ch, cfg_div,
`ifdef FDIV_SYNC_EN
      output sync,
`endif
      input  cfg_ready, clk_out, tick, pending
   );

   modport slave (
      input  en, cfg_valid, cfg_ch, cfg_div,
`ifdef FDIV_SYNC_EN
      input  sync,
`endif
      output cfg_ready, clk_out, tick, pending
   );
endinterface

// File: rtl/freq_divider_prog.sv
// freq_divider_prog: NUM_CH independent runtime-programmable clock dividers.
// Each channel produces a 50%-duty divided clock (half-period = D cycles) and
// a one-cycle tick on every toggle. New divisors go to a shadow register and
// are only applied at a half-period boundary, while idle, or while parked,
// so a running half-period is never shortened or stretched.
// Optional macro FDIV_SYNC_EN: adds bus.sync, which holds every channel as if
// its enable were low; releasing it phase-aligns channels with equal D.
module freq_divider_prog #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 1
) (
   input  logic               clk,
   input  logic               rst,
   freq_divider_prog_if.slave bus
);
   localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] ZERO    = {DIV_W{1'b0}};

   logic [DIV_W-1:0]  cnt_r    [NUM_CH];
   logic [DIV_W-1:0]  div_r    [NUM_CH];
   logic [DIV_W-1:0]  shadow_r [NUM_CH];
   logic [NUM_CH-1:0] clk_out_r;
   logic [NUM_CH-1:0] tick_r;
   logic [NUM_CH-1:0] pending_r;

   logic [NUM_CH-1:0] hit_s;
   logic [NUM_CH-1:0] accept_s;
   logic [NUM_CH-1:0] idle_s;
   logic [NUM_CH-1:0] tc_s;
   logic              cfg_ready_s;

   // Decode the config target; an out-of-range channel number hits nothing
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         hit_s[c] = (bus.cfg_ch == CH_W'(c));
      end
   end

   // Ready only blocks when the addressed channel still has a shadow in flight;
   // out-of-range requests see ready=1 and are silently dropped
   assign cfg_ready_s   = ~|(hit_s & pending_r);
   assign accept_s      = hit_s & {NUM_CH{bus.cfg_valid & cfg_ready_s}};
   assign bus.cfg_ready = cfg_ready_s;

   // Per-channel hold condition (disabled, synced or parked at D=0) and terminal count
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
`ifdef FDIV_SYNC_EN
         idle_s[c] = ~bus.en[c] | bus.sync | (div_r[c] == ZERO);
`else
         idle_s[c] = ~bus.en[c] | (div_r[c] == ZERO);
`endif
         // Only meaningful when div_r != 0; idle_s takes priority otherwise
         tc_s[c]   = (cnt_r[c] == (div_r[c] - ONE));
      end
   end

   // Channel counters, divided clocks, ticks and shadow-divisor hand-over
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            cnt_r[c]    <= ZERO;
            div_r[c]    <= DEF_DIV;
            shadow_r[c] <= ZERO;
         end
         clk_out_r <= {NUM_CH{1'b0}};
         tick_r    <= {NUM_CH{1'b0}};
         pending_r <= {NUM_CH{1'b0}};
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (idle_s[c]) begin
               cnt_r[c]     <= ZERO;
               clk_out_r[c] <= 1'b0;
               tick_r[c]    <= 1'b0;
               if (pending_r[c]) begin
                  div_r[c]     <= shadow_r[c];
                  pending_r[c] <= 1'b0;
               end
            end else if (tc_s[c]) begin
               cnt_r[c]     <= ZERO;
               clk_out_r[c] <= ~clk_out_r[c];
               tick_r[c]    <= 1'b1;
               // The half-period that just ended used the old D; the new one starts now
               if (pending_r[c]) begin
                  div_r[c]     <= shadow_r[c];
                  pending_r[c] <= 1'b0;
               end
            end else begin
               cnt_r[c]  <= cnt_r[c] + ONE;
               tick_r[c] <= 1'b0;
            end
            // Accept only happens with pending low, so it never collides with an apply
            if (accept_s[c]) begin
               shadow_r[c]  <= bus.cfg_div;
               pending_r[c] <= 1'b1;
            end
         end
      end
   end

   assign bus.clk_out = clk_out_r;
   assign bus.tick    = tick_r;
   assign bus.pending = pending_r;
endmodule

// File: tb/tb_freq_divider_prog.sv
// Testbench for freq_divider_prog: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against an
// event-time reference model (each channel tracks when its current
// half-period began and when it must end).
module tb_freq_divider_prog;
   localparam int NUM_CH      = 4;
   localparam int DIV_W       = 16;
   localparam int DEFAULT_DIV = 1;
   localparam int CH_W        = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   freq_divider_prog_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_W(CH_W)) bus ();

   freq_divider_prog #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   int m_div    [NUM_CH];
   int m_shadow [NUM_CH];
   bit m_pend   [NUM_CH];
   bit m_lvl    [NUM_CH];
   bit m_tick   [NUM_CH];
   int m_start  [NUM_CH];   // edge index at which the current half-period started
   int cyc = 0;             // index of the most recent clock edge

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_div[c]    = DEFAULT_DIV;
         m_shadow[c] = 0;
         m_pend[c]   = 1'b0;
         m_lvl[c]    = 1'b0;
         m_tick[c]   = 1'b0;
         m_start[c]  = cyc + 1;
      end
   endtask

   task automatic model_step(input logic [NUM_CH-1:0] en_v, input logic sync_v,
                             input logic valid_v, input logic ready_v,
                             input int ch_v, input int div_v);
      bit hold;
      for (int c = 0; c < NUM_CH; c++) begin
         hold = !en_v[c] || sync_v || (m_div[c] == 0);
         if (hold) begin
            m_lvl[c]   = 1'b0;
            m_tick[c]  = 1'b0;
            m_start[c] = cyc + 1;
            if (m_pend[c]) begin
               m_div[c]  = m_shadow[c];
               m_pend[c] = 1'b0;
            end
         end else if (cyc - m_start[c] == m_div[c] - 1) begin
            m_lvl[c]   = !m_lvl[c];
            m_tick[c]  = 1'b1;
            m_start[c] = cyc + 1;
            if (m_pend[c]) begin
               m_div[c]  = m_shadow[c];
               m_pend[c] = 1'b0;
            end
         end else begin
            m_tick[c] = 1'b0;
         end
      end
      if (valid_v && ready_v && ch_v < NUM_CH) begin
         m_shadow[ch_v] = div_v;
         m_pend[ch_v]   = 1'b1;
      end
   endtask

   // Per-cycle compare: inputs and cfg_ready sampled mid-cycle, registered outputs just after the edge
   initial begin : compare_proc
      logic              s_rst;
      logic              s_valid;
      logic              s_ready;
      logic              s_sync;
      logic [NUM_CH-1:0] s_en;
      logic [NUM_CH-1:0] e_clk;
      logic [NUM_CH-1:0] e_tick;
      logic [NUM_CH-1:0] e_pend;
      int                s_ch;
      int                s_div;
      forever begin
         @(negedge clk);
         s_rst   = rst;
         s_en    = bus.en;
         s_valid = bus.cfg_valid;
         s_ch    = int'(bus.cfg_ch);
         s_div   = int'(bus.cfg_div);
`ifdef FDIV_SYNC_EN
         s_sync  = bus.sync;
`else
         s_sync  = 1'b0;
`endif
         s_ready = (s_ch < NUM_CH) ? !m_pend[s_ch] : 1'b1;
         if (!s_rst) check("cfg_ready", 32'(bus.cfg_ready), 32'(s_ready));
         @(posedge clk);
         cyc++;
         #1;
         if (s_rst) model_reset();
         else model_step(s_en, s_sync, s_valid, s_ready, s_ch, s_div);
         for (int c = 0; c < NUM_CH; c++) begin
            e_clk[c]  = m_lvl[c];
            e_tick[c] = m_tick[c];
            e_pend[c] = m_pend[c];
         end
         check("clk_out", 32'(bus.clk_out), 32'(e_clk));
         check("tick", 32'(bus.tick), 32'(e_tick));
         check("pending", 32'(bus.pending), 32'(e_pend));
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic req(input int ch, input int d);
      bus.cfg_valid = 1'b1;
      bus.cfg_ch    = CH_W'(ch);
      bus.cfg_div   = DIV_W'(d);
      #1;
   endtask

   task automatic idle();
      bus.cfg_valid = 1'b0;
   endtask

   // Directed scenarios, then randomized traffic
   initial begin : stim_proc
      int idx;
      bus.en        = 4'b0000;
      bus.cfg_valid = 1'b0;
      bus.cfg_ch    = 2'd0;
      bus.cfg_div   = 16'd0;
`ifdef FDIV_SYNC_EN
      bus.sync      = 1'b0;
`endif
      step(3);
      check("rst_clk_out", 32'(bus.clk_out), 32'd0);
      check("rst_tick", 32'(bus.tick), 32'd0);
      check("rst_pending", 32'(bus.pending), 32'd0);
      check("rst_ready", 32'(bus.cfg_ready), 32'd1);

      // 1: default D=1 on ch0 -> toggle and tick every cycle
      rst    = 1'b0;
      bus.en = 4'b0001;
      step();
      check("t1_clk_a", 32'(bus.clk_out[0]), 32'd1);
      check("t1_tick_a", 32'(bus.tick[0]), 32'd1);
      step();
      check("t1_clk_b", 32'(bus.clk_out[0]), 32'd0);
      check("t1_tick_b", 32'(bus.tick[0]), 32'd1);

      // 2: load ch1 D=3 while disabled, then run it
      req(1, 3);
      check("t2_ready", 32'(bus.cfg_ready), 32'd1);
      step();
      idle();
      check("t2_pend_set", 32'(bus.pending[1]), 32'd1);
      step();
      check("t2_pend_clr", 32'(bus.pending[1]), 32'd0);
      bus.en = 4'b0011;
      step();
      check("t2_tick_first", 32'(bus.tick[1]), 32'd0);
      step(2);
      check("t2_clk_rise", 32'(bus.clk_out[1]), 32'd1);
      check("t2_tick_rise", 32'(bus.tick[1]), 32'd1);
      step(3);
      check("t2_clk_fall", 32'(bus.clk_out[1]), 32'd0);
      check("t2_tick_fall", 32'(bus.tick[1]), 32'd1);

      // 3/4: ch2 at D=4, reload D=2 mid half-period, busy request, ch3 meanwhile
      req(2, 4);
      step();
      idle();
      step();
      bus.en = 4'b0111;
      step(5);
      req(2, 2);
      step();
      check("t3_pend_set", 32'(bus.pending[2]), 32'd1);
      req(2, 7);
      check("t4_ready_busy", 32'(bus.cfg_ready), 32'd0);
      step();
      check("t3_pend_hold", 32'(bus.pending[2]), 32'd1);
      check("t3_clk_hold", 32'(bus.clk_out[2]), 32'd1);
      req(3, 2);
      check("t4_ready_ch3", 32'(bus.cfg_ready), 32'd1);
      step();
      idle();
      check("t3_clk_tc", 32'(bus.clk_out[2]), 32'd0);
      check("t3_tick_tc", 32'(bus.tick[2]), 32'd1);
      check("t3_pend_clr", 32'(bus.pending[2]), 32'd0);
      check("t4_pend_ch3", 32'(bus.pending[3]), 32'd1);
      step();
      check("t3_tick_mid", 32'(bus.tick[2]), 32'd0);
      check("t4_pend_ch3_clr", 32'(bus.pending[3]), 32'd0);
      step();
      check("t3_clk_short", 32'(bus.clk_out[2]), 32'd1);
      check("t3_tick_short", 32'(bus.tick[2]), 32'd1);

      // 5: park ch0 with D=0, then restart with D=5
      req(0, 0);
      step();
      idle();
      check("t5_pend_set", 32'(bus.pending[0]), 32'd1);
      step();
      check("t5_pend_clr", 32'(bus.pending[0]), 32'd0);
      step(3);
      check("t5_parked_clk", 32'(bus.clk_out[0]), 32'd0);
      check("t5_parked_tick", 32'(bus.tick[0]), 32'd0);
      req(0, 5);
      step();
      idle();
      check("t5_reload_pend", 32'(bus.pending[0]), 32'd1);
      step();
      check("t5_reload_applied", 32'(bus.pending[0]), 32'd0);
      step(4);
      check("t5_clk_wait", 32'(bus.clk_out[0]), 32'd0);
      step();
      check("t5_clk_rise", 32'(bus.clk_out[0]), 32'd1);
      check("t5_tick_rise", 32'(bus.tick[0]), 32'd1);

      // 6: async reset with a pending shadow
      req(1, 6);
      step();
      idle();
      check("t6_pend_set", 32'(bus.pending[1]), 32'd1);
      rst = 1'b1;
      #1;
      check("t6_async_clk", 32'(bus.clk_out), 32'd0);
      check("t6_async_tick", 32'(bus.tick), 32'd0);
      check("t6_async_pend", 32'(bus.pending), 32'd0);
      step();
      rst = 1'b0;
      step();
      check("t6_default_div", 32'(bus.clk_out[2:0]), 32'd7);
`ifdef FDIV_SYNC_EN
      bus.sync = 1'b1;
      step();
      check("t6_sync_hold", 32'(bus.clk_out[1:0]), 32'd0);
      bus.sync = 1'b0;
      step();
      check("t6_sync_align_a", 32'(bus.clk_out[1:0]), 32'd3);
      step();
      check("t6_sync_align_b", 32'(bus.clk_out[1:0]), 32'd0);
`endif

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end
         if ($urandom_range(0, 19) == 0) begin
            idx = int'($urandom_range(0, NUM_CH - 1));
            bus.en[idx] = ~bus.en[idx];
         end
         bus.cfg_valid = ($urandom_range(0, 3) == 0);
         bus.cfg_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
         bus.cfg_div   = DIV_W'($urandom_range(0, 6));
`ifdef FDIV_SYNC_EN
         bus.sync      = ($urandom_range(0, 99) == 0);
`endif
         step();
      end
      idle();
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
